// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline slices.
package pipe_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  // Counter width able to hold 0..SKID_DEPTH*n inclusive.
  function automatic int unsigned occ_width(input int unsigned n);
    return $clog2(SKID_DEPTH * n + 1);
  endfunction

endpackage

// File: rtl/skid_slice.sv
// One elastic slice: main entry M feeds downstream, skid entry S absorbs the beat
// that arrives in the cycle the registered ready could not yet drop.
module skid_slice
  import pipe_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter logic [W-1:0] RST_VECT = '0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_flush,
  input  logic                              i_up_valid,
  output logic                              o_up_ready,
  input  logic [W-1:0]                      i_up_data,
  output logic                              o_dn_valid,
  input  logic                              i_dn_ready,
  output logic [W-1:0]                      o_dn_data,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   o_cnt
);

  logic         r_m_valid;
  logic         r_s_valid;
  logic [W-1:0] r_m_data;
  logic [W-1:0] r_s_data;

  logic w_up_acc;
  logic w_m_free;

  // Ready is a pure register output, so no ready path threads through the chain.
  assign o_up_ready = ~r_s_valid;
  assign o_dn_valid = r_m_valid;
  assign o_dn_data  = r_m_data;

  assign w_up_acc = i_up_valid & ~r_s_valid;
  assign w_m_free = ~r_m_valid | i_dn_ready;

  assign o_cnt = {1'b0, r_m_valid} + {1'b0, r_s_valid};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= RST_VECT;
      r_s_data  <= RST_VECT;
    end else if (i_flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= '0;
      r_s_data  <= '0;
    end else if (w_m_free) begin
      if (r_s_valid) begin
        r_m_valid <= 1'b1;
        r_m_data  <= r_s_data;
        r_s_valid <= w_up_acc;
        if (w_up_acc) begin
          r_s_data <= i_up_data;
        end
      end else begin
        r_m_valid <= w_up_acc;
        if (w_up_acc) begin
          r_m_data <= i_up_data;
        end
      end
    end else if (w_up_acc) begin
      r_s_valid <= 1'b1;
      r_s_data  <= i_up_data;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Chain of NSTAGES skid slices with a registered occupancy counter.
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned  W        = 32,
  parameter int unsigned  NSTAGES  = 1,
  parameter logic [W-1:0] RST_VECT = '0,
  localparam int unsigned OCC_W    = occ_width(NSTAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [OCC_W-1:0] occupancy
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(SKID_DEPTH * NSTAGES);

  logic             w_valid [NSTAGES+1];
  logic             w_ready [NSTAGES+1];
  logic [W-1:0]     w_data  [NSTAGES+1];
  logic [CNT_W-1:0] w_cnt   [NSTAGES];

  logic             w_acc;
  logic             w_emit;
  logic [OCC_W-1:0] r_occ;

  assign w_valid[0]       = in_valid;
  assign w_data[0]        = in_data;
  assign in_ready         = w_ready[0] & ~rst;
  assign out_valid        = w_valid[NSTAGES];
  assign out_data         = w_data[NSTAGES];
  assign w_ready[NSTAGES] = out_ready;

  for (genvar g = 0; g < NSTAGES; g++) begin : g_slice
    skid_slice #(
      .W        (W),
      .RST_VECT (RST_VECT)
    ) u_slice (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_flush    (flush),
      .i_up_valid (w_valid[g]),
      .o_up_ready (w_ready[g]),
      .i_up_data  (w_data[g]),
      .o_dn_valid (w_valid[g+1]),
      .i_dn_ready (w_ready[g+1]),
      .o_dn_data  (w_data[g+1]),
      .o_cnt      (w_cnt[g])
    );
  end

  assign w_acc  = in_valid & in_ready;
  assign w_emit = out_valid & out_ready;

  // A beat emitted during flush still leaves, but the flush zeroes the count anyway.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else begin
      unique case ({w_acc, w_emit})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occupancy = r_occ;

`ifndef SYNTHESIS
  logic [OCC_W-1:0] w_pop;
  logic             r_chk_armed;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < int'(NSTAGES); k++) begin
      w_pop = w_pop + OCC_W'(w_cnt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_armed <= 1'b1;
    end
    if (r_chk_armed && !rst) begin
      assert (r_occ == w_pop);
      assert (r_occ <= OCC_MAX);
      assert (!(w_emit && !w_acc && r_occ == '0));
      assert (!(w_acc && !w_emit && !flush && r_occ == OCC_MAX));
    end
  end
`endif

endmodule
